// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared types for the intersection phase scheduler:
// phase encoding, light encodings and the phase-to-light decode.
package intersection_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLR_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLR_B  = 3'd5,
    WALK   = 3'd6
  } phase_e;

  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
  } lights_t;

  function automatic lights_t light_decode(phase_e s);
    lights_t l;
    l.main = LIGHT_RED;
    l.side = LIGHT_RED;
    unique case (s)
      MAIN_G: l.main = LIGHT_GREEN;
      MAIN_Y: l.main = LIGHT_YELLOW;
      SIDE_G: l.side = LIGHT_GREEN;
      SIDE_Y: l.side = LIGHT_YELLOW;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Demand inputs and light/walk outputs of the phase scheduler.
// master drives demand, slave is the scheduler.
interface intersection_phase_scheduler_if;
  logic       side_sense;
  logic       ped_req;
  logic       preempt;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output side_sense, ped_req, preempt,
    input  main_light, side_light, walk, ped_ack, phase
  );

  modport slave (
    input  side_sense, ped_req, preempt,
    output main_light, side_light, walk, ped_ack, phase
  );
endinterface

// File: rtl/intersection_phase_scheduler_timer.sv
// Saturating phase counter; clr restarts it at zero.
// Duration compares live in the scheduler.
module phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != CMAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road plus pedestrian phase sequencer with emergency preempt.
// Outputs are registered from the next phase.
module intersection_phase_scheduler
  import intersection_pkg::*;
#(
  parameter int GREEN_MAIN   = 10,
  parameter int GREEN_SIDE   = 6,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int WALK_TIME    = 5,
  parameter int CNT_W        = 5
) (
  input logic                         clk,
  input logic                         rst,
  intersection_phase_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] T_GM = CNT_W'(GREEN_MAIN - 1);
  localparam logic [CNT_W-1:0] T_GS = CNT_W'(GREEN_SIDE - 1);
  localparam logic [CNT_W-1:0] T_Y  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] T_AR = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] T_W  = CNT_W'(WALK_TIME - 1);

  phase_e           state;
  phase_e           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             side_pend;
  logic             ped_pend;
  logic             enter_side;
  logic             enter_walk;
  lights_t          lt_d;
  logic             walk_d;
  logic             ack_d;
  logic [2:0]       main_q;
  logic [2:0]       side_q;
  logic             walk_q;
  logic             ack_q;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_nx != state),
    .cnt (cnt)
  );

  assign enter_side = (state_nx == SIDE_G) && (state != SIDE_G);
  assign enter_walk = (state_nx == WALK) && (state != WALK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MAIN_G;
      main_q <= LIGHT_GREEN;
      side_q <= LIGHT_RED;
      walk_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      main_q <= lt_d.main;
      side_q <= lt_d.side;
      walk_q <= walk_d;
      ack_q  <= ack_d;
    end
  end

  // A request arriving on the entry edge is re-latched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
    end else begin
      side_pend <= bus.side_sense | (side_pend & ~enter_side);
      ped_pend  <= bus.ped_req | (ped_pend & ~enter_walk);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      MAIN_G:
        if (cnt >= T_GM && (side_pend || ped_pend) && !bus.preempt)
          state_nx = MAIN_Y;
      MAIN_Y:
        if (cnt == T_Y) state_nx = CLR_A;
      CLR_A:
        if (cnt == T_AR) begin
          if (bus.preempt)   state_nx = MAIN_G;
          else if (ped_pend) state_nx = WALK;
          else               state_nx = SIDE_G;
        end
      WALK:
        if (bus.preempt)     state_nx = CLR_B;
        else if (cnt == T_W) state_nx = side_pend ? SIDE_G : MAIN_G;
      SIDE_G:
        if (bus.preempt || cnt == T_GS) state_nx = SIDE_Y;
      SIDE_Y:
        if (cnt == T_Y) state_nx = CLR_B;
      CLR_B:
        if (cnt == T_AR) state_nx = MAIN_G;
      default:
        state_nx = MAIN_G;
    endcase
  end

  always_comb begin
    lt_d   = light_decode(state_nx);
    walk_d = (state_nx == WALK);
    ack_d  = enter_walk;
  end

  assign bus.main_light = main_q;
  assign bus.side_light = side_q;
  assign bus.walk       = walk_q;
  assign bus.ped_ack    = ack_q;
  assign bus.phase      = state;

endmodule
